// File: rtl/tpram_gen.sv
// Two-port synchronous RAM with byte enables, read-valid flag, optional output register
// and a zero-fill clear sequencer. Optional macro TPRAM_GEN_BYPASS_EN adds same-address write forwarding.
module tpram_gen #(
  parameter int AW   = 7,
  parameter int DW   = 32,
  parameter int OREG = 0
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clear,
  output logic            o_busy,
  input  logic            i_wren,
  input  logic [AW-1:0]   i_wraddress,
  input  logic [DW/8-1:0] i_byteena,
  input  logic [DW-1:0]   i_data,
  input  logic            i_rden,
  input  logic [AW-1:0]   i_rdaddress,
  output logic [DW-1:0]   o_q,
  output logic            o_qvalid
);
  localparam int BW = DW / 8;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_busy;
  logic            w_rd_acc;
  logic [BW-1:0]   w_we_lanes;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   r_mem [0:(1<<AW)-1];
  logic [DW-1:0]   r_ram_q;
  logic            r_v1;
  logic [DW-1:0]   w_rd_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The clear sequencer shares the single write port with user writes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_we_lanes  = '0;
    w_waddr     = i_wraddress;
    w_wdata     = i_data;
    case (r_state)
      S_CLEAR: begin
        w_busy     = 1'b1;
        w_we_lanes = '1;
        w_waddr    = r_cnt;
        w_wdata    = '0;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == {AW{1'b1}}) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (i_wren) w_we_lanes = i_byteena;
        if (i_clear) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign o_busy   = w_busy;
  assign w_rd_acc = (r_state == S_IDLE) && i_rden;

  always_ff @(posedge i_clock) begin
    for (int i = 0; i < BW; i++) begin
      if (w_we_lanes[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ram_q <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) r_ram_q <= r_mem[i_rdaddress];
    end
  end

`ifdef TPRAM_GEN_BYPASS_EN
  logic [BW-1:0] r_fwd_be;
  logic [DW-1:0] r_fwd_data;

  // Forwarding state only moves with a read so q still holds when rden is low.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else if (w_rd_acc) begin
      r_fwd_be   <= (i_wren && (i_wraddress == i_rdaddress)) ? i_byteena : '0;
      r_fwd_data <= i_data;
    end
  end

  always_comb begin
    w_rd_q = r_ram_q;
    for (int i = 0; i < BW; i++) begin
      if (r_fwd_be[i]) w_rd_q[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end
`else
  assign w_rd_q = r_ram_q;
`endif

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] r_q2;
      logic          r_v2;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_q2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_q2 <= w_rd_q;
        end
      end
      assign o_q      = r_q2;
      assign o_qvalid = r_v2;
    end else begin : g_noreg
      assign o_q      = w_rd_q;
      assign o_qvalid = r_v1;
    end
  endgenerate

endmodule

// File: tb/tb_tpram_gen.sv
// Bench for tpram_gen: OREG=0 and OREG=1 instances share stimulus and are checked
// against an array/latency reference model; honours TPRAM_GEN_BYPASS_EN.
module tb_tpram_gen;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic [BW-1:0] be = '0;
  logic [DW-1:0] d = '0;
  logic          busy0, busy1, v0, v1;
  logic [DW-1:0] q0, q1;

  always #5 clk = ~clk;

  tpram_gen #(.AW(AW), .DW(DW), .OREG(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_clear(clr), .o_busy(busy0),
    .i_wren(wren), .i_wraddress(wa), .i_byteena(be), .i_data(d),
    .i_rden(rden), .i_rdaddress(ra), .o_q(q0), .o_qvalid(v0));

  tpram_gen #(.AW(AW), .DW(DW), .OREG(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_clear(clr), .o_busy(busy1),
    .i_wren(wren), .i_wraddress(wa), .i_byteena(be), .i_data(d),
    .i_rden(rden), .i_rdaddress(ra), .o_q(q1), .o_qvalid(v1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: array contents, remaining clear cycles, and read results by latency.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_left;
  int            m_clr_idx;
  logic          m_v1, m_v2;
  logic [DW-1:0] m_q1, m_q2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic          busy_b;
    logic          rd_iss;
    logic [DW-1:0] rv;
    busy_b = (m_clr_left > 0);
    rd_iss = !busy_b && rden;
    rv     = m_mem[ra];
`ifdef TPRAM_GEN_BYPASS_EN
    if (rd_iss && wren && (wa == ra)) begin
      for (int i = 0; i < BW; i++) if (be[i]) rv[8*i +: 8] = d[8*i +: 8];
    end
`endif
    if (m_v1) m_q2 = m_q1;
    m_v2 = m_v1;
    if (rd_iss) m_q1 = rv;
    m_v1 = rd_iss;
    if (busy_b) begin
      m_mem[m_clr_idx] = '0;
      m_clr_idx++;
      m_clr_left--;
    end else begin
      if (wren) begin
        for (int i = 0; i < BW; i++) if (be[i]) m_mem[wa][8*i +: 8] = d[8*i +: 8];
      end
      if (clr) begin
        m_clr_left = DEPTH;
        m_clr_idx  = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("busy0", 32'(busy0), 32'(m_clr_left > 0));
    check_eq("busy1", 32'(busy1), 32'(m_clr_left > 0));
    check_eq("qvalid_l1", 32'(v0), 32'(m_v1));
    check_eq("q_l1", q0, m_q1);
    check_eq("qvalid_l2", 32'(v1), 32'(m_v2));
    check_eq("q_l2", q1, m_q2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    wren = 1'b0;
    rden = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_idle();
    m_clr_left = DEPTH;
    m_clr_idx  = 0;
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    m_q1 = '0;
    m_q2 = '0;
    @(posedge clk);
    #2;
    check_eq("rst_q0", q0, 32'h0);
    check_eq("rst_v0", 32'(v0), 32'h0);
    check_eq("rst_q1", q1, 32'h0);
    check_eq("rst_v1", 32'(v1), 32'h0);
    check_eq("rst_busy", 32'(busy0), 32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd, output int n);
    n = 0;
    while (busy0 && n < 400) begin
      if (rnd) begin
        wren = 1'($urandom_range(0, 1));
        rden = 1'($urandom_range(0, 1));
        clr  = 1'($urandom_range(0, 1));
        wa   = AW'($urandom);
        ra   = AW'($urandom);
        be   = BW'($urandom);
        d    = $urandom;
      end
      step();
      n++;
    end
    set_idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic [BW-1:0] b);
    wren = 1'b1; wa = a; d = v; be = b;
    step();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rden = 1'b1; ra = a;
    step();
    rden = 1'b0;
  endtask

  int            n_busy;
  logic [DW-1:0] exp9;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    apply_reset();
    wait_idle(1'b0, n_busy);
    check_eq("busy_len_reset", n_busy, 32'd128);

    rd(7'd0);
    check_eq("rd0_q", q0, 32'h0);
    check_eq("rd0_v_l1", 32'(v0), 32'h1);
    check_eq("rd0_v_l2_early", 32'(v1), 32'h0);
    step();
    check_eq("rd0_v_l2", 32'(v1), 32'h1);
    rd(7'd64);
    rd(7'd127);
    check_eq("rd127_q", q0, 32'h0);
    step();
    step();

    wr(7'd5, 32'hDEADBEEF, 4'b1111);
    wr(7'd5, 32'h00005500, 4'b0010);
    wr(7'd5, 32'hFFFFFFFF, 4'b0000);
    rd(7'd5);
    check_eq("rd5_l1", q0, 32'hDEAD55EF);
    step();
    check_eq("rd5_l2", q1, 32'hDEAD55EF);
    check_eq("rd5_v_l2", 32'(v1), 32'h1);

    wr(7'd9, 32'h11111111, 4'b1111);
    wren = 1'b1; wa = 7'd9; d = 32'h22222222; be = 4'b0011;
    rden = 1'b1; ra = 7'd9;
    step();
    set_idle();
`ifdef TPRAM_GEN_BYPASS_EN
    exp9 = 32'h11112222;
`else
    exp9 = 32'h11111111;
`endif
    check_eq("rdw9", q0, exp9);
    rd(7'd9);
    check_eq("rd9_after", q0, 32'h11112222);
    step();

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hA5A5A5A5, 4'b1111);
    rd(7'd33);
    check_eq("rd_fill", q0, 32'hA5A5A5A5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    wait_idle(1'b1, n_busy);
    check_eq("busy_len_clear", n_busy, 32'd128);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    check_eq("rd_cleared_127", q0, 32'h0);
    step();

    wr(7'd127, 32'h7F7F0001, 4'b1111);
    wr(7'd0, 32'h00C0FFEE, 4'b1111);
    wr(7'd1, 32'h01234567, 4'b1111);
    rden = 1'b1; ra = 7'd127;
    step();
    check_eq("b2b_127", q0, 32'h7F7F0001);
    ra = 7'd0;
    step();
    check_eq("b2b_0", q0, 32'h00C0FFEE);
    ra = 7'd1;
    step();
    check_eq("b2b_1", q0, 32'h01234567);
    check_eq("b2b_v", 32'(v0), 32'h1);
    rden = 1'b0;
    step();
    check_eq("b2b_drop_v", 32'(v0), 32'h0);
    check_eq("b2b_hold_q", q0, 32'h01234567);
    step();
    check_eq("b2b_drop_v_l2", 32'(v1), 32'h0);
    check_eq("b2b_hold_q_l2", q1, 32'h01234567);

    for (int c = 0; c < 3000; c++) begin
      wren = 1'($urandom_range(0, 1));
      rden = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 399) == 0);
      wa   = AW'($urandom_range(0, 7));
      ra   = AW'($urandom_range(0, 7));
      be   = BW'($urandom);
      d    = $urandom;
      step();
    end
    set_idle();
    wait_idle(1'b0, n_busy);

    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 49; c++) step();
    apply_reset();
    wait_idle(1'b1, n_busy);
    check_eq("busy_len_midreset", n_busy, 32'd128);
    rd(7'd5);
    check_eq("rd_after_midreset", q0, 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tpram_gen.md
# tpram_gen

Parametrised two-port synchronous RAM: one write port, one read port, one clock. It adds to the plain 128x32 two-port RAM:
- per-byte write enables
- a read-enable with a valid flag
- an optional output pipeline register
- a hardware clear sequencer that zero-fills the array after reset or on request

It serves as the common storage primitive under the SDRAM cache/tag arrays and FIFOs. It infers block RAM for the array.

## Interface
Parameters:
- AW, 7, address width; depth = 2^AW words
- DW, 32, data width; must be a multiple of 8
- OREG, 0, 1 = extra output register stage (read latency 2), 0 = latency 1

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous request to zero-fill the whole array
- busy  out  1  clear sequence in progress
- wren  in  1  write enable
- wraddress  in  AW  write address
- byteena  in  DW/8  per-byte write enable; bit i covers data[8i+7:8i]
- data  in  DW  write data
- rden  in  1  read enable
- rdaddress  in  AW  read address
- q  out  DW  read data
- qvalid  out  1  q holds the result of a read request

## Operation
- The array itself is never reset. Only the state, counter, q, qvalid and pipeline registers are reset.
- Clear FSM states:
  - CLEAR: busy=1. Writes zero to mem[cnt], then cnt <= cnt+1. On the cycle cnt = 2^AW-1 is written, go to IDLE.
  - IDLE: busy=0. clear=1 sampled in IDLE → cnt <= 0, go to CLEAR.
- Reset assertion forces state=CLEAR, cnt=0. The array is therefore cleared after every reset release.
- Reset mid-clear restarts the sequence at address 0.
- clear asserted while already in CLEAR is ignored; the sequence is not restarted.
- While busy=1:
  - wren and rden are ignored.
  - No read is issued, so qvalid stays 0.
- Write (IDLE, wren=1): each byte lane with byteena[i]=1 is updated from data. Lanes with byteena[i]=0 keep their contents. wren=1 with byteena=0 is a no-op.
- Read (IDLE, rden=1): mem[rdaddress] is returned on q with qvalid=1 after the latency below.
- rden=0: qvalid drops to 0 after the same latency, and q holds its last value.
- Read and write to different addresses in the same cycle are independent.
- Same-address read and write in the same cycle: behaviour is set by the macro (see Configuration).
- Addresses are plain AW-bit values, with no wrap logic needed. The clear counter is AW+1 bits wide or uses an explicit terminal compare, so it never aliases.

## Timing
- Reset values: q=0, qvalid=0, busy=1, state=CLEAR, cnt=0. OREG stage registers are also reset to 0.
- Clear duration: exactly 2^AW cycles from the first rising edge after reset release. For AW=7 that is 128 cycles.
- busy deasserts on the edge after the last zero write. The first accepted access is in the cycle busy=0 is seen.
- clear request in IDLE: busy=1 from the next edge, for 2^AW cycles.
- OREG=0: read request sampled at edge n → q/qvalid valid after edge n+1.
- OREG=1: read request sampled at edge n → q/qvalid valid after edge n+2.
- Throughput: one read and one write per cycle, fully pipelined.
- A write at edge n is visible to a read sampled at edge n+1 or later.

## Configuration
- Macro: TPRAM_GEN_BYPASS_EN
- Defined: same-cycle same-address read-during-write returns new data per lane.
  - Lanes with byteena[i]=1 return data.
  - Other lanes return the old contents.
  - Implemented with a registered forwarding compare and mux in front of q or the OREG stage.
- Undefined: a same-cycle same-address read returns the old contents (read-before-write). There is no forwarding logic.
- The macro does not change latency in either case.

## Test plan
- Reset release with AW=7 → busy=1 for exactly 128 cycles. Then read addr 0, 64 and 127 → q=0x00000000, qvalid=1 one cycle after rden (OREG=0).
- Write 0xDEADBEEF at addr 5 with byteena=4'b1111. Then write 0x00005500 at addr 5 with byteena=4'b0010. Read 5 → q=0xDEAD55EF. Changing OREG=1 makes qvalid arrive 2 cycles after rden.
- Same-cycle wren/rden at addr 9, which holds 0x11111111, with data=0x22222222 and byteena=4'b0011:
  - TPRAM_GEN_BYPASS_EN defined → q=0x11112222.
  - Undefined → q=0x11111111.
  - A following read of 9 → 0x11112222 in both builds.
- Pulse clear in IDLE after filling addr 0..127 with 0xA5A5A5A5 → busy=1 for 128 cycles, and writes/reads during busy are ignored (qvalid=0). Afterwards every address reads 0.
- Assert reset at cycle 50 of a clear, then release → busy stays high for a full 128 cycles from release, and q=0 and qvalid=0 during reset.
- Back-to-back reads of addr 127, 0, 1 on consecutive cycles, with rden dropped on the 4th cycle → q streams the three words with qvalid=1 for three consecutive cycles. Then qvalid=0 and q holds the addr-1 word.
